// File: rtl/mean_rank_sorter.sv
// Collects (mean, index) pairs into an insertion-sorted register array, then
// streams the indices out in ascending mean order (stable for equal means).
module mean_rank_sorter #(
    parameter int unsigned N_IMAGES = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned MEAN_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [MEAN_W-1:0] in_mean,
    input  logic [IDX_W-1:0]  in_index,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [MEAN_W-1:0] out_mean,
    output logic [IDX_W-1:0]  out_rank,
    output logic              busy,
    output logic              sort_done
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    ptr;
    logic [N_IMAGES-1:0] slot_vld;
    logic [MEAN_W-1:0]   slot_mean [N_IMAGES];
    logic [IDX_W-1:0]    slot_idx  [N_IMAGES];
    logic [CNT_W-1:0]    ins_pos;
    logic                accept;

    assign accept = in_valid && (state == FILL);

    // Insert position: filled slots whose mean is <= the new one stay ahead of it.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < int'(N_IMAGES); i++) begin
            if (slot_vld[i] && (slot_mean[i] <= in_mean)) begin
                ins_pos = ins_pos + CNT_W'(1);
            end
        end
    end

    // Control state: fill counter, emit pointer and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            count    <= '0;
            ptr      <= '0;
            slot_vld <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        slot_vld <= {slot_vld[N_IMAGES-2:0], 1'b1};
                        count    <= count + CNT_W'(1);
                        if (count == CNT_W'(N_IMAGES - 1)) begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (ptr == IDX_W'(N_IMAGES - 1)) begin
                            state <= DONE;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slot payload: shift the tail up by one and drop the new pair into the gap.
    // Stale data after reset is masked by slot_vld, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (ins_pos == '0) begin
                slot_mean[0] <= in_mean;
                slot_idx[0]  <= in_index;
            end
            for (int i = 1; i < int'(N_IMAGES); i++) begin
                if (CNT_W'(i) == ins_pos) begin
                    slot_mean[i] <= in_mean;
                    slot_idx[i]  <= in_index;
                end else if ((CNT_W'(i) > ins_pos) && (CNT_W'(i) <= count)) begin
                    slot_mean[i] <= slot_mean[i-1];
                    slot_idx[i]  <= slot_idx[i-1];
                end
            end
        end
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == EMIT);
    assign busy      = (state != DONE);
    assign sort_done = (state == DONE);
    assign out_rank  = ptr;
    assign out_index = (state == FILL) ? '0 : slot_idx[ptr];
    assign out_mean  = (state == FILL) ? '0 : slot_mean[ptr];

endmodule
